// File: rtl/uart_snd.sv
// uart_snd: transmit-side framer for the board-to-board UART link.
// Captures four nibbles on send_req and feeds them to the UART tx core as
// two bytes: {inH2,inL2} first, then {inH,inL}.
// Optional build macro UART_SND_CHK_EN: appends a third byte (b0 ^ b1)
// after a second gap; without it the START3/WAIT3 logic does not exist.
//
// Handshake: send_req is a request sampled only in IDLE (no queueing);
// tx_start is a one-cycle command to the tx core with din stable from the
// START cycle to the end of the matching WAIT; tx_done_tick is the core's
// one-cycle completion and is honoured only in a WAIT state.
module uart_snd #(
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send_req,
   input  logic [3:0] inH,
   input  logic [3:0] inL,
   input  logic [3:0] inH2,
   input  logic [3:0] inL2,
   input  logic       tx_done_tick,
   output logic       tx_start,
   output logic [7:0] din,
   output logic       busy,
   output logic       done_tick,
   output logic       err_tick,
   output logic [3:0] state_dbg
);

   localparam int GAP_MAX = (GAP_CYCLES > 1) ? GAP_CYCLES : 1;
   localparam int TO_MAX  = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES : 1;
   localparam int GW      = $clog2(GAP_MAX) + 1;
   localparam int TW      = $clog2(TO_MAX) + 1;

   // Last counter value before leaving GAP / declaring a timeout.
   localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
   localparam logic [TW-1:0] TO_LAST  = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_START1 = 4'd1,
      S_WAIT1  = 4'd2,
      S_GAP    = 4'd3,
      S_START2 = 4'd4,
      S_WAIT2  = 4'd5,
      S_DONE   = 4'd6
`ifdef UART_SND_CHK_EN
      ,
      S_START3 = 4'd7,
      S_WAIT3  = 4'd8
`endif
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      b0_q, b0_d;
   logic [7:0]      b1_q, b1_d;
   logic [7:0]      din_q, din_d;
   logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
   logic [TW-1:0]   to_cnt_q, to_cnt_d;
   logic            tx_start_q, tx_start_d;
   logic            busy_q, busy_d;
   logic            done_tick_q, done_tick_d;
   logic            err_tick_q, err_tick_d;
`ifdef UART_SND_CHK_EN
   // Set once the second gap (before the check byte) has been entered.
   logic            chk_phase_q, chk_phase_d;
`endif

   // Next-state and next-output logic; outputs are computed for the state
   // being entered so every output comes straight from a flop.
   always_comb begin
      state_d     = state_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      din_d       = din_q;
      gap_cnt_d   = gap_cnt_q;
      to_cnt_d    = to_cnt_q;
      tx_start_d  = 1'b0;
      done_tick_d = 1'b0;
      err_tick_d  = 1'b0;
`ifdef UART_SND_CHK_EN
      chk_phase_d = chk_phase_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (send_req) begin
               b0_d       = {inH2, inL2};
               b1_d       = {inH, inL};
               din_d      = {inH2, inL2};
               tx_start_d = 1'b1;
               state_d    = S_START1;
`ifdef UART_SND_CHK_EN
               chk_phase_d = 1'b0;
`endif
            end
         end
         S_START1: begin
            state_d  = S_WAIT1;
            to_cnt_d = '0;
         end
         S_START2: begin
            state_d  = S_WAIT2;
            to_cnt_d = '0;
         end
`ifdef UART_SND_CHK_EN
         S_START3: begin
            state_d  = S_WAIT3;
            to_cnt_d = '0;
         end
`endif
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               tx_start_d = 1'b1;
`ifdef UART_SND_CHK_EN
               if (chk_phase_q) begin
                  state_d = S_START3;
                  din_d   = b0_q ^ b1_q;
               end else begin
                  state_d = S_START2;
                  din_d   = b1_q;
               end
`else
               state_d = S_START2;
               din_d   = b1_q;
`endif
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end
         S_WAIT1, S_WAIT2
`ifdef UART_SND_CHK_EN
         , S_WAIT3
`endif
         : begin
            if (tx_done_tick) begin
               case (state_q)
                  S_WAIT1: begin
                     if (GAP_CYCLES == 0) begin
                        state_d    = S_START2;
                        din_d      = b1_q;
                        tx_start_d = 1'b1;
                     end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                     end
                  end
`ifdef UART_SND_CHK_EN
                  S_WAIT2: begin
                     chk_phase_d = 1'b1;
                     if (GAP_CYCLES == 0) begin
                        state_d    = S_START3;
                        din_d      = b0_q ^ b1_q;
                        tx_start_d = 1'b1;
                     end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                     end
                  end
`endif
                  default: begin
                     state_d     = S_DONE;
                     done_tick_d = 1'b1;
                  end
               endcase
            end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LAST)) begin
               // Abort: no further bytes, back to IDLE with an error pulse.
               state_d    = S_IDLE;
               err_tick_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State, captured bytes, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         b0_q        <= 8'h00;
         b1_q        <= 8'h00;
         din_q       <= 8'h00;
         gap_cnt_q   <= '0;
         to_cnt_q    <= '0;
         tx_start_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_tick_q <= 1'b0;
         err_tick_q  <= 1'b0;
`ifdef UART_SND_CHK_EN
         chk_phase_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         din_q       <= din_d;
         gap_cnt_q   <= gap_cnt_d;
         to_cnt_q    <= to_cnt_d;
         tx_start_q  <= tx_start_d;
         busy_q      <= busy_d;
         done_tick_q <= done_tick_d;
         err_tick_q  <= err_tick_d;
`ifdef UART_SND_CHK_EN
         chk_phase_q <= chk_phase_d;
`endif
      end
   end

   assign tx_start  = tx_start_q;
   assign din       = din_q;
   assign busy      = busy_q;
   assign done_tick = done_tick_q;
   assign err_tick  = err_tick_q;
   assign state_dbg = state_q;

endmodule
